dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipelined core's EX/MEM memory port and a word-wide main-memory port. Hits are answered combinationally in the MEM cycle. Misses raise `cache_resp_stall` until the line has been written back if dirty and refilled, at which point the core's held request hits. The block is the responder that generates the core's `cache_resp_stall` input.

---
 rtl/dcache_ctrl.sv | 148 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache, 4-word lines
// Optional statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [6:0]  cpu_opcode,
  output logic [31:0] cpu_rdata,
  output logic        cache_resp_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RF} state_e;

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [IDX_W-1:0]   midx_q;
  logic [TAG_W-1:0]   mtag_q;
  logic [31:0]        data_q [0:SETS-1][0:3];
  logic [TAG_W-1:0]   tag_q  [0:SETS-1];
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;

  logic               req;
  logic               hit;
  logic               store;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         wsel;
  logic               unused_addr_lsb;

  assign idx   = cpu_addr[3+IDX_W:4];
  assign tag   = cpu_addr[31:4+IDX_W];
  assign wsel  = cpu_addr[3:2];
  assign req   = (cpu_opcode == OP_LOAD) || (cpu_opcode == OP_STORE);
  assign hit   = req && valid_q[idx] && (tag_q[idx] == tag);
  assign store = req && cpu_we;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign cpu_rdata        = data_q[idx][wsel];
  assign cache_resp_stall = !rst && ((state_q != S_IDLE) || (req && !hit));

  // Memory side depends only on registered state so mem_ack never feeds back combinationally.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state_q)
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[midx_q], midx_q, cnt_q, 2'b00};
        mem_wdata = data_q[midx_q][cnt_q];
      end
      S_RF: begin
        mem_req   = 1'b1;
        mem_addr  = {mtag_q, midx_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      midx_q  <= '0;
      mtag_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit && store) begin
            data_q[idx][wsel] <= cpu_wdata;
            dirty_q[idx]      <= 1'b1;
          end else if (req && !hit) begin
            midx_q  <= idx;
            mtag_q  <= tag;
            cnt_q   <= 2'd0;
            state_q <= (valid_q[idx] && dirty_q[idx]) ? S_WB : S_RF;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              dirty_q[midx_q] <= 1'b0;
              state_q         <= S_RF;
            end
          end
        end
        S_RF: begin
          if (mem_ack) begin
            data_q[midx_q][cnt_q] <= mem_rdata;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              tag_q[midx_q]   <= mtag_q;
              valid_q[midx_q] <= 1'b1;
              dirty_q[midx_q] <= 1'b0;
              state_q         <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The retry after a refill is an ordinary IDLE hit, so it is counted as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (state_q == S_IDLE) begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      else if (req) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a flat-memory reference model
module tb_dcache_ctrl;
  localparam int SETS = 16;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we;
  logic [6:0]  cpu_opcode;
  logic        cache_resp_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_opcode(cpu_opcode),
    .cpu_rdata(cpu_rdata), .cache_resp_stall(cache_resp_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    int          stalls;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  bit          mon_en = 1'b0;
  int          hit_e = 0;
  int          miss_e = 0;
  logic [31:0] ram  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  bit          m_valid [SETS];
  bit          m_dirty [SETS];
  bit [23:0]   m_tag   [SETS];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef DCACHE_STATS_EN
    return hit_e;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef DCACHE_STATS_EN
    return miss_e;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_counters();
    check("hit_cnt", hit_cnt, exp_hits());
    check("miss_cnt", miss_cnt, exp_misses());
  endtask

  // The cache must behave as plain memory; stall length follows from which lines are resident.
  task automatic issue(input bit st, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    logic [3:0]  s;
    bit [23:0]   t;
    bit          h;
    exp_t        e;
    int          n;
    wa = {a[31:2], 2'b00};
    s  = a[7:4];
    t  = a[31:8];
    h  = m_valid[s] && (m_tag[s] == t);
    e.stalls = h ? 0 : 1 + ((m_valid[s] && m_dirty[s]) ? 8 : 4) * (lat + 1);
    e.chk    = !st;
    e.data   = gold_rd(wa);
    sb.push_back(e);
    if (!h) begin
      miss_e++;
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    hit_e++;
    if (st) begin
      m_dirty[s] = 1'b1;
      gold[wa]   = d;
    end
    cpu_addr   = {a[31:2], 2'($urandom)};
    cpu_opcode = st ? ST : LD;
    cpu_we     = st;
    cpu_wdata  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (!cache_resp_stall) break;
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: stall still %b after %0d cycles, expected release", cache_resp_stall, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_opcode = 7'b0010011;
    cpu_we     = 1'($urandom);
  endtask

  // Monitor: counts stall cycles of the presented request and pops on completion.
  initial begin
    int   sc;
    exp_t e;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) sc = 0;
      else if (cpu_opcode == LD || cpu_opcode == ST) begin
        if (cache_resp_stall) sc++;
        else begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got completion, expected none");
          end else begin
            e = sb.pop_front();
            check("stall_cycles", sc, e.stalls);
            if (e.chk) check("load_data", cpu_rdata, e.data);
          end
          sc = 0;
        end
      end
    end
  end

  // Main-memory responder with programmable ack latency; spurious acks while idle.
  initial begin
    int          wc;
    logic [31:0] pa;
    wc = 0;
    pa = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        wc = 0;
        check("idle_mem_out", mem_addr | mem_wdata | {31'b0, mem_we}, 32'h0);
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end else begin
        if (wc > 0) check("addr_held", mem_addr, pa);
        pa = mem_addr;
        if (wc >= lat) begin
          check("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
          if (mem_we) begin
            check("wb_data", mem_wdata, gold_rd(mem_addr));
            ram[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = ram_rd(mem_addr);
          end
          mem_ack = 1'b1;
          wc = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          wc++;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit          found;
    int          r;
    rst        = 1'b1;
    cpu_opcode = 7'b0;
    cpu_addr   = 32'h0;
    cpu_wdata  = 32'h0;
    cpu_we     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ram[32'h100 + 4*i]  = 32'hA0 + i;
      gold[32'h100 + 4*i] = 32'hA0 + i;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, cache_resp_stall}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_stall", {31'b0, cache_resp_stall}, 32'h0);
    check_counters();
    mon_en = 1'b1;

    issue(1'b0, 32'h100, 32'h0);
    check_counters();
    issue(1'b1, 32'h104, 32'hDEADBEEF);
    issue(1'b0, 32'h104, 32'h0);
    issue(1'b0, 32'h500, 32'h0);
    lat = 2;
    issue(1'b0, 32'h900, 32'h0);
    lat = 0;
    check_counters();

    // Abort a refill with reset during word 2.
    mon_en     = 1'b0;
    cpu_addr   = 32'h1200;
    cpu_opcode = LD;
    cpu_we     = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr[3:2] == 2'd2) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL rf_word2_timeout: refill word 2 not seen, expected within 50 cycles");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_req", {31'b0, mem_req}, 32'h0);
    check("abort_stall", {31'b0, cache_resp_stall}, 32'h0);
    cpu_opcode = 7'b0;
    rst = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    hit_e  = 0;
    miss_e = 0;
    gold   = ram;
    @(posedge clk);
    #1;
    check_counters();
    mon_en = 1'b1;
    issue(1'b0, 32'h1200, 32'h0);

    for (int i = 0; i < 8; i++) begin
      cpu_opcode = 7'b0110011;
      cpu_addr   = (i % 2 == 0) ? 32'h1200 : $urandom;
      cpu_we     = 1'($urandom);
      cpu_wdata  = $urandom;
      @(posedge clk);
      #1;
      check("nonreq_stall", {31'b0, cache_resp_stall}, 32'h0);
      check("nonreq_mem_req", {31'b0, mem_req}, 32'h0);
    end
    check_counters();
    issue(1'b0, 32'h1200, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 9);
      lat = $urandom_range(0, 2);
      a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
            (32'($urandom_range(0, 3)) << 2);
      if (r == 0) begin
        cpu_opcode = 7'b0110011;
        cpu_we     = 1'b1;
        cpu_addr   = a;
        cpu_wdata  = $urandom;
        @(posedge clk);
        #1;
      end else begin
        issue(r < 5, a, $urandom);
      end
    end
    lat = 0;
    check_counters();
    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
